// File: rtl/net_input_conditioner_pkg.sv
`default_nettype none
// ============================================================================
// Module   : net_input_conditioner_pkg
// Purpose  : Shared types and constants for the network input conditioner.
// Revision : 1.0  initial release
// ============================================================================
package net_input_conditioner_pkg;

  localparam int SAMPLE_W      = 16;
  localparam int UNPLUGGED_RAW = -32000;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CH0    = 3'd1,
    CH1    = 3'd2,
    CH2    = 3'd3,
    CH3    = 3'd4,
    COMMIT = 3'd5
  } in_state_t;

  // Channel handled by the shared datapath in a given state (0 outside CHi).
  function automatic logic [1:0] chan_of(input in_state_t s);
    case (s)
      CH1:     chan_of = 2'd1;
      CH2:     chan_of = 2'd2;
      CH3:     chan_of = 2'd3;
      default: chan_of = 2'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/net_input_conditioner_sync_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : net_input_conditioner_sync_edge_detect
// Purpose  : Two-flop synchroniser for an asynchronous level plus a one-cycle
//            rising-edge pulse in the clk domain.
// Revision : 1.0  initial release
// ============================================================================
module net_input_conditioner_sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise_pulse
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  // Shift the asynchronous level through the synchroniser and history flop.
  always_comb begin
    sync1_d = async_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // Synchroniser and history registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign rise_pulse = sync2_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/net_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : net_input_conditioner
// Purpose  : Snapshots four codec samples on each synchronised sample_clk
//            rising edge, conditions them one channel per cycle through a
//            shared datapath (mask, unplugged sentinel, >>>IN_SHIFT) and
//            commits all four outputs together with a one-cycle out_strobe.
//            Edges arriving while busy are dropped and counted.
//            Optional macro NET_IN_LPF_EN adds a per-channel one-pole
//            smoother after scaling.
// Revision : 1.0  initial release
// ============================================================================
module net_input_conditioner
  import net_input_conditioner_pkg::*;
#(
  parameter int         W         = SAMPLE_W,
  parameter logic [3:0] CH_MASK   = 4'b0111,
  parameter int         UNPLUGGED = UNPLUGGED_RAW,
  parameter int         IN_SHIFT  = 2,
  parameter int         LPF_SHIFT = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_clk,
  input  logic signed [W-1:0] sample_in0,
  input  logic signed [W-1:0] sample_in1,
  input  logic signed [W-1:0] sample_in2,
  input  logic signed [W-1:0] sample_in3,
  input  logic [7:0]          jack,
  output logic signed [W-1:0] cond_out0,
  output logic signed [W-1:0] cond_out1,
  output logic signed [W-1:0] cond_out2,
  output logic signed [W-1:0] cond_out3,
  output logic                out_strobe,
  output logic                busy,
  output logic [7:0]          overrun_cnt
);

  localparam logic signed [W-1:0] UNP_W      = W'(UNPLUGGED);
  localparam logic signed [W-1:0] UNP_SCALED = UNP_W >>> IN_SHIFT;

  logic                sample_edge;
  in_state_t           state_q, state_d;
  logic [3:0][W-1:0]   snap_q, snap_d;
  logic [3:0]          jack_q, jack_d;
  logic [2:0][W-1:0]   work_q, work_d;
  logic [3:0][W-1:0]   cond_q, cond_d;
  logic                out_strobe_q, out_strobe_d;
  logic                busy_q, busy_d;
  logic [7:0]          ovr_q, ovr_d;
  logic [1:0]          ch_idx;
  logic signed [W-1:0] ch_x;
  logic signed [W-1:0] ch_res;
  logic                unused_jack_hi;

  assign unused_jack_hi = ^jack[7:4];

  net_input_conditioner_sync_edge_detect u_sync (
    .clk       (clk),
    .rst       (rst),
    .async_in  (sample_clk),
    .rise_pulse(sample_edge)
  );

`ifdef NET_IN_LPF_EN
  logic [3:0][W-1:0]   y_q, y_d;
  logic signed [W-1:0] y_cur;
  logic signed [W:0]   lpf_diff;
  logic signed [W:0]   lpf_step;

  // Shared channel datapath: mask, sentinel, scale, then one-pole smoothing.
  always_comb begin
    ch_idx = chan_of(state_q);
    if (!CH_MASK[ch_idx])      ch_x = '0;
    else if (!jack_q[ch_idx])  ch_x = UNP_SCALED;
    else                       ch_x = $signed(snap_q[ch_idx]) >>> IN_SHIFT;
    y_cur    = $signed(y_q[ch_idx]);
    lpf_diff = {ch_x[W-1], ch_x} - {y_cur[W-1], y_cur};
    lpf_step = lpf_diff >>> LPF_SHIFT;
    // Unplugged channels jump straight to the sentinel instead of gliding.
    if (!CH_MASK[ch_idx])      ch_res = '0;
    else if (!jack_q[ch_idx])  ch_res = UNP_SCALED;
    else                       ch_res = y_cur + lpf_step[W-1:0];
    y_d = y_q;
    if (state_q inside {CH0, CH1, CH2, CH3}) y_d[ch_idx] = ch_res;
  end

  // Filter state registers.
  always_ff @(posedge clk) begin
    if (rst) y_q <= '0;
    else     y_q <= y_d;
  end
`else
  localparam int unused_lpf_shift = LPF_SHIFT;

  // Shared channel datapath: mask, unplugged sentinel, arithmetic scaling.
  always_comb begin
    ch_idx = chan_of(state_q);
    if (!CH_MASK[ch_idx])      ch_x = '0;
    else if (!jack_q[ch_idx])  ch_x = UNP_SCALED;
    else                       ch_x = $signed(snap_q[ch_idx]) >>> IN_SHIFT;
    ch_res = ch_x;
  end
`endif

  // Sequencer next-state, snapshot capture, commit and overrun counting.
  always_comb begin
    state_d      = state_q;
    snap_d       = snap_q;
    jack_d       = jack_q;
    work_d       = work_q;
    cond_d       = cond_q;
    out_strobe_d = 1'b0;
    busy_d       = busy_q;
    ovr_d        = ovr_q;
    // Any edge outside IDLE (including COMMIT) is dropped and counted.
    if (sample_edge && (state_q != IDLE) && (ovr_q != 8'hFF)) ovr_d = ovr_q + 8'd1;
    case (state_q)
      IDLE: begin
        if (sample_edge) begin
          snap_d  = {sample_in3, sample_in2, sample_in1, sample_in0};
          jack_d  = jack[3:0];
          busy_d  = 1'b1;
          state_d = CH0;
        end
      end
      CH0: begin
        work_d[0] = ch_res;
        state_d   = CH1;
      end
      CH1: begin
        work_d[1] = ch_res;
        state_d   = CH2;
      end
      CH2: begin
        work_d[2] = ch_res;
        state_d   = CH3;
      end
      CH3: begin
        // All four outputs land together so they never mix samples.
        cond_d       = {ch_res, work_q[2], work_q[1], work_q[0]};
        out_strobe_d = 1'b1;
        state_d      = COMMIT;
      end
      COMMIT: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer, snapshot, work and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      snap_q       <= '0;
      jack_q       <= '0;
      work_q       <= '0;
      cond_q       <= '0;
      out_strobe_q <= 1'b0;
      busy_q       <= 1'b0;
      ovr_q        <= '0;
    end else begin
      state_q      <= state_d;
      snap_q       <= snap_d;
      jack_q       <= jack_d;
      work_q       <= work_d;
      cond_q       <= cond_d;
      out_strobe_q <= out_strobe_d;
      busy_q       <= busy_d;
      ovr_q        <= ovr_d;
    end
  end

  assign cond_out0   = cond_q[0];
  assign cond_out1   = cond_q[1];
  assign cond_out2   = cond_q[2];
  assign cond_out3   = cond_q[3];
  assign out_strobe  = out_strobe_q;
  assign busy        = busy_q;
  assign overrun_cnt = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_net_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_net_input_conditioner
// Purpose  : Directed self-checking bench for net_input_conditioner.
// Revision : 1.0  initial release
// ============================================================================
module tb_net_input_conditioner;

  logic               clk = 1'b0;
  logic               rst;
  logic               sample_clk;
  logic signed [15:0] sample_in0, sample_in1, sample_in2, sample_in3;
  logic [7:0]         jack;
  logic signed [15:0] cond_out0, cond_out1, cond_out2, cond_out3;
  logic               out_strobe;
  logic               busy;
  logic [7:0]         overrun_cnt;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;

  net_input_conditioner dut (
    .clk        (clk),
    .rst        (rst),
    .sample_clk (sample_clk),
    .sample_in0 (sample_in0),
    .sample_in1 (sample_in1),
    .sample_in2 (sample_in2),
    .sample_in3 (sample_in3),
    .jack       (jack),
    .cond_out0  (cond_out0),
    .cond_out1  (cond_out1),
    .cond_out2  (cond_out2),
    .cond_out3  (cond_out3),
    .out_strobe (out_strobe),
    .busy       (busy),
    .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  // Count strobe cycles on the inactive edge.
  always @(negedge clk) if (out_strobe === 1'b1) strobe_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One isolated sample: lat = ticks from pin rise to strobe (-1 if none).
  task automatic run_sample(output int lat, output int busy_n);
    lat = -1;
    busy_n = 0;
    sample_clk = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 3) sample_clk = 1'b0;
      if (busy === 1'b1) busy_n++;
      if (out_strobe === 1'b1 && lat < 0) lat = i;
    end
  endtask

  initial begin
    int lat, bn, s0;
    rst = 1'b1; sample_clk = 1'b0; jack = 8'h00;
    sample_in0 = '0; sample_in1 = '0; sample_in2 = '0; sample_in3 = '0;
    repeat (3) tick();
    chk("rst_out0", cond_out0, 0);
    chk("rst_out1", cond_out1, 0);
    chk("rst_out2", cond_out2, 0);
    chk("rst_out3", cond_out3, 0);
    chk("rst_strobe", out_strobe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun_cnt, 0);
    rst = 1'b0;
    repeat (3) tick();

    // Full-scale, negative, mid and masked channel; latency = 2 sync + 5.
    jack = 8'h0F; sample_in0 = 16'h7FFF; sample_in1 = -16'sd4;
    sample_in2 = 16'sd100; sample_in3 = 16'sd1234;
    s0 = strobe_cnt;
    run_sample(lat, bn);
    chk("t1_latency", lat, 7);
    chk("t1_busy_cycles", bn, 5);
    chk("t1_strobes", strobe_cnt - s0, 1);
    chk("t1_out0", cond_out0, 16'sh1FFF);
    chk("t1_out1", cond_out1, -1);
    chk("t1_out2", cond_out2, 25);
    chk("t1_out3_masked", cond_out3, 0);

    // All unplugged: sentinel on live channels, masked stays 0.
    jack = 8'h00; sample_in0 = 16'sd500; sample_in1 = -16'sd900;
    sample_in2 = 16'h1234; sample_in3 = 16'sd77;
    run_sample(lat, bn);
    chk("t2_out0", cond_out0, -8000);
    chk("t2_out1", cond_out1, -8000);
    chk("t2_out2", cond_out2, -8000);
    chk("t2_out3", cond_out3, 0);

    // Second edge three cycles after the first is dropped.
    jack = 8'h0F; sample_in0 = 16'sd400;
    s0 = strobe_cnt;
    sample_clk = 1'b1; tick(); tick();   // edge cycle E
    sample_clk = 1'b0; tick();           // CH0
    sample_clk = 1'b1; tick(); tick();   // edge at E+3
    sample_clk = 1'b0;
    repeat (12) tick();
    chk("t3_strobes", strobe_cnt - s0, 1);
    chk("t3_ovr", overrun_cnt, 1);
    chk("t3_out0", cond_out0, 100);
    // Edges every two cycles: two of every three are overruns.
    for (int k = 0; k < 600; k++) begin
      sample_clk = 1'b1; tick();
      sample_clk = 1'b0; tick();
    end
    repeat (10) tick();
    chk("t3_ovr_sat", overrun_cnt, 8'hFF);

    // Inputs changed during CH1 must not reach the committed result.
    jack = 8'h0F; sample_in0 = 16'sd800;
    s0 = strobe_cnt;
    sample_clk = 1'b1; tick(); tick();   // E
    tick(); tick();                      // CH0, CH1
    sample_in0 = -16'sd800; jack = 8'h00; sample_clk = 1'b0;
    repeat (10) tick();
    chk("t4_strobes", strobe_cnt - s0, 1);
    chk("t4_out0_snapshot", cond_out0, 200);

    // Reset in CH2 aborts without a strobe.
    jack = 8'h0F; sample_in0 = 16'sd40;
    s0 = strobe_cnt;
    sample_clk = 1'b1; tick(); tick();   // E
    tick(); tick(); tick();              // CH0, CH1, CH2
    chk("t5_busy_ch2", busy, 1);
    rst = 1'b1; sample_clk = 1'b0;
    tick();
    chk("t5_out0", cond_out0, 0);
    chk("t5_busy", busy, 0);
    chk("t5_ovr", overrun_cnt, 0);
    rst = 1'b0;
    repeat (8) tick();
    chk("t5_no_strobe", strobe_cnt - s0, 0);
    run_sample(lat, bn);
    chk("t5_after_latency", lat, 7);
    chk("t5_after_out0", cond_out0, 10);

`ifdef NET_IN_LPF_EN
    // Step response of the smoother, then unplug jumps to the sentinel.
    rst = 1'b1; tick(); rst = 1'b0; repeat (3) tick();
    jack = 8'h0F; sample_in0 = 16'sd800;
    run_sample(lat, bn);
    chk("t6_lpf_1", cond_out0, 25);
    run_sample(lat, bn);
    chk("t6_lpf_2", cond_out0, 46);
    run_sample(lat, bn);
    chk("t6_lpf_3", cond_out0, 65);
    jack = 8'h00;
    run_sample(lat, bn);
    chk("t6_lpf_unplug", cond_out0, -8000);
`else
    // Unfiltered step lands immediately; negative shift rounds toward -inf.
    jack = 8'h0F; sample_in0 = 16'sd800; sample_in1 = -16'sd7;
    run_sample(lat, bn);
    chk("t6_step_out0", cond_out0, 200);
    chk("t6_neg_out1", cond_out1, -2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
